mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the core controller (master) and the memory responder (slave).
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory with a req/ready handshake and WAIT_CYCLES wait states.
// Optional MEM_ALIGN_CHECK_EN: misaligned requests complete with err instead of accessing memory.
module mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gWaitRangeCheck
        $error("mem_responder: WAIT_CYCLES must be within 0..15");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > 30) begin : gAddrRangeCheck
        $error("mem_responder: ADDR_BITS must be within 1..30");
    end

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   accessNow;
    logic                   accessFire;

    logic                   we_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [31:0]            wdata_q;
    logic [3:0]             be_q;
    logic                   mis_q;

    logic                   accWe;
    logic [ADDR_BITS-1:0]   accIdx;
    logic [31:0]            accWdata;
    logic [3:0]             accBe;
    logic                   accMis;
    logic                   reqMis;

    logic [31:0]            rdata_q;
    logic                   errFlag_q;
    logic [31:0]            mem [DEPTH];

    logic                   unusedAddrBits;
    assign unusedAddrBits = ^{bus.addr[31:ADDR_BITS+2], bus.addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign reqMis = (bus.addr[1:0] != 2'b00);
`else
    assign reqMis = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accessNow = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        accessNow = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    accessNow = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state_q == DONE);
        bus.busy  = (state_q != IDLE);
        bus.err   = (state_q == DONE) && errFlag_q;
        bus.rdata = rdata_q;
    end

    // With zero wait states the access happens on the accept edge, so the live request is used.
    always_comb begin
        if (state_q == IDLE) begin
            accWe    = bus.we;
            accIdx   = bus.addr[ADDR_BITS+1:2];
            accWdata = bus.wdata;
            accBe    = bus.be;
            accMis   = reqMis;
        end else begin
            accWe    = we_q;
            accIdx   = idx_q;
            accWdata = wdata_q;
            accBe    = be_q;
            accMis   = mis_q;
        end
    end

    assign accessFire = accessNow && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            mis_q   <= 1'b0;
        end else if (state_q == IDLE && bus.req) begin
            we_q    <= bus.we;
            idx_q   <= bus.addr[ADDR_BITS+1:2];
            wdata_q <= bus.wdata;
            be_q    <= bus.be;
            mis_q   <= reqMis;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q   <= 32'd0;
            errFlag_q <= 1'b0;
        end else if (accessFire) begin
            errFlag_q <= accMis;
            if (!accWe && !accMis) begin
                rdata_q <= mem[accIdx];
            end
        end
    end

    // The array has no reset; accessFire is gated by rst so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (accessFire && accWe && !accMis) begin
            for (int i = 0; i < 4; i++) begin
                if (accBe[i]) begin
                    mem[accIdx][8*i +: 8] <= accWdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance for timing/data/reset checks
// and a WAIT_CYCLES=0 instance for back-to-back accesses.
module tb_mem_responder;

    localparam int WAIT_CYCLES = 2;

    logic clk;
    logic rstN;
    logic rstN0;
    int   checkCount;
    int   errorCount;
    logic [31:0] rd;

    logic [31:0] fastAddr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] fastData [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

    mem_responder_if bus();
    mem_responder_if bus0();

    mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk (clk),
        .rst (rstN),
        .bus (bus)
    );

    mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rstN0),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One complete access on the WAIT_CYCLES=2 instance, checking latency, busy span and pulse width.
    task automatic applyStimulus(input string tag, input logic isWrite, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] b, input logic expErr,
                                 output logic [31:0] rdOut);
        int lat;
        int busyCnt;
        logic seen;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = isWrite;
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = b;
        @(posedge clk); #1;
        bus.req = 1'b0;
        lat     = 0;
        busyCnt = bus.busy ? 1 : 0;
        seen    = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busyCnt++;
            if (bus.ready) seen = 1'b1;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES));
        checkOutput({tag, "_busyCycles"}, 32'(busyCnt), 32'(WAIT_CYCLES + 1));
        checkOutput({tag, "_err"}, 32'(bus.err), 32'(expErr));
        rdOut = bus.rdata;
        @(posedge clk); #1;
        checkOutput({tag, "_readyPulse"}, 32'(bus.ready), 32'd0);
        checkOutput({tag, "_busyAfter"}, 32'(bus.busy), 32'd0);
    endtask

    // Four accesses on the zero-wait instance with req held high throughout.
    task automatic fastBurst(input logic isWrite);
        @(negedge clk);
        bus0.req   = 1'b1;
        bus0.we    = isWrite;
        bus0.be    = 4'hF;
        bus0.addr  = fastAddr[0];
        bus0.wdata = fastData[0];
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checkOutput("fast_readyHigh", 32'(bus0.ready), 32'd1);
            checkOutput("fast_busyHigh", 32'(bus0.busy), 32'd1);
            if (!isWrite) checkOutput("fast_rdata", bus0.rdata, fastData[k]);
            if (k < 3) begin
                bus0.addr  = fastAddr[k+1];
                bus0.wdata = fastData[k+1];
            end else begin
                bus0.req = 1'b0;
            end
            @(posedge clk); #1;
            checkOutput("fast_readyLow", 32'(bus0.ready), 32'd0);
            checkOutput("fast_busyLow", 32'(bus0.busy), 32'd0);
        end
    endtask

    initial begin
        int n;
        checkCount = 0;
        errorCount = 0;
        rstN  = 1'b0;
        rstN0 = 1'b0;
        bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = 32'd0;  bus.wdata = 32'd0;  bus.be = 4'd0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0; bus0.be = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(bus.ready), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_err", 32'(bus.err), 32'd0);
        checkOutput("reset_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        rstN  = 1'b1;
        rstN0 = 1'b1;

        applyStimulus("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        applyStimulus("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd);
        checkOutput("rd10_data", rd, 32'hDEADBEEF);

        applyStimulus("wr20", 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd);
        applyStimulus("wr20lanes", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd);
        checkOutput("write_keeps_rdata", rd, 32'hDEADBEEF);
        applyStimulus("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd);
        checkOutput("rd20_lanes", rd, 32'h11BB33DD);
        applyStimulus("wr20none", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, rd);
        applyStimulus("rd20again", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd);
        checkOutput("rd20_noopWrite", rd, 32'h11BB33DD);

        // A second request raised during WAIT must be dropped, not queued.
        applyStimulus("wr64", 1'b1, 32'h64, 32'h64646464, 4'hF, 1'b0, rd);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h60; bus.wdata = 32'h600D600D; bus.be = 4'hF;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.addr = 32'h64; bus.wdata = 32'hFFFFFFFF;
        n = 0;
        while (!bus.ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ignore_latency", 32'(n), 32'(WAIT_CYCLES));
        bus.req = 1'b0;
        @(posedge clk); #1;
        checkOutput("ignore_notQueued", 32'(bus.busy), 32'd0);
        applyStimulus("rd60", 1'b0, 32'h60, 32'h0, 4'h0, 1'b0, rd);
        checkOutput("rd60_original", rd, 32'h600D600D);
        applyStimulus("rd64", 1'b0, 32'h64, 32'h0, 4'h0, 1'b0, rd);
        checkOutput("rd64_untouched", rd, 32'h64646464);

        // Reset lands one cycle before the access edge of a pending write.
        applyStimulus("wr40zero", 1'b1, 32'h40, 32'h0, 4'hF, 1'b0, rd);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.wdata = 32'hCAFEF00D; bus.be = 4'hF;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        checkOutput("midReset_ready", 32'(bus.ready), 32'd0);
        checkOutput("midReset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midReset_rdata", bus.rdata, 32'd0);
        @(posedge clk); #1;
        checkOutput("midReset_readyHeld", 32'(bus.ready), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus("rd40", 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd);
        checkOutput("rd40_abortedWrite", rd, 32'h0);

        applyStimulus("wr1000", 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 1'b0, rd);
        applyStimulus("rd0", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd);
        checkOutput("wrap_data", rd, 32'h5A5A5A5A);
        applyStimulus("rd10b", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd);
        checkOutput("rd10b_data", rd, 32'hDEADBEEF);
`ifdef MEM_ALIGN_CHECK_EN
        applyStimulus("rd2", 1'b0, 32'h2, 32'h0, 4'h0, 1'b1, rd);
        checkOutput("misaligned_rdataKept", rd, 32'hDEADBEEF);
`else
        applyStimulus("rd2", 1'b0, 32'h2, 32'h0, 4'h0, 1'b0, rd);
        checkOutput("unaligned_containingWord", rd, 32'h5A5A5A5A);
`endif

        fastBurst(1'b1);
        fastBurst(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
